// File: rtl/iq_int_param.sv
// iq_int_param: parametrised integer issue queue between dispatch (DU) and the integer issue unit (IU).
// Entries are held in age order at indices 0..count-1, with index 0 the oldest.
// CDB broadcasts wake the entries' sources. Each cycle one entry is selected: the oldest ready JR if
// there is one, otherwise the oldest ready entry. An issue collapses the hole in a single cycle.
// A selective flush removes every entry at or younger than the flushing ROB tag.
//
// Optional feature: define IQ_INT_WAKEUP_BYPASS_EN to wake a dispatching entry's sources from the
// CDB broadcast in the same cycle. Without the macro the DU rdy bits are stored verbatim.
//
// Ports:
//   clk, reset                        posedge clock, synchronous active-high reset
//   du_w_*                            dispatch write (payload, rs/rt pid+rdy, rob tag, jr)
//   iq_full                           no free entry (registered state only)
//   cdb_flush, cdb_rob_tag, rob_r_ptr selective flush request and ROB head for age compare
//   cdb_reg_wr, cdb_rd_pid            CDB wakeup broadcast
//   iq_rdy, iq_r_*                    selected entry (combinational on registered state)
//   iu_r_en                           IU takes the selected entry this cycle
module iq_int_param #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned PID_W     = 6,
    parameter int unsigned ROB_TAG_W = 5,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 du_w_en,
    input  logic [PAYLOAD_W-1:0] du_w_payload,
    input  logic [PID_W-1:0]     du_w_rs_pid,
    input  logic                 du_w_rs_rdy,
    input  logic [PID_W-1:0]     du_w_rt_pid,
    input  logic                 du_w_rt_rdy,
    input  logic [ROB_TAG_W-1:0] du_w_rob_tag,
    input  logic                 du_w_jr,
    output logic                 iq_full,
    input  logic                 cdb_flush,
    input  logic [ROB_TAG_W-1:0] cdb_rob_tag,
    input  logic [ROB_TAG_W-1:0] rob_r_ptr,
    input  logic                 cdb_reg_wr,
    input  logic [PID_W-1:0]     cdb_rd_pid,
    output logic                 iq_rdy,
    output logic [PAYLOAD_W-1:0] iq_r_payload,
    output logic [PID_W-1:0]     iq_r_rs_pid,
    output logic [PID_W-1:0]     iq_r_rt_pid,
    output logic [ROB_TAG_W-1:0] iq_r_rob_tag,
    output logic                 iq_r_jr,
    input  logic                 iu_r_en
);
    localparam int unsigned SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic                 r_valid   [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [PID_W-1:0]     r_rs_pid  [DEPTH];
    logic                 r_rs_rdy  [DEPTH];
    logic [PID_W-1:0]     r_rt_pid  [DEPTH];
    logic                 r_rt_rdy  [DEPTH];
    logic [ROB_TAG_W-1:0] r_rob_tag [DEPTH];
    logic                 r_jr      [DEPTH];
    logic [CNT_W-1:0]     r_count;

    // Post-wakeup view with an extra all-zero slot at index DEPTH, so the collapse always reads i+1
    logic                 w_valid_wk   [DEPTH+1];
    logic [PAYLOAD_W-1:0] w_payload_wk [DEPTH+1];
    logic [PID_W-1:0]     w_rs_pid_wk  [DEPTH+1];
    logic                 w_rs_rdy_wk  [DEPTH+1];
    logic [PID_W-1:0]     w_rt_pid_wk  [DEPTH+1];
    logic                 w_rt_rdy_wk  [DEPTH+1];
    logic [ROB_TAG_W-1:0] w_rob_tag_wk [DEPTH+1];
    logic                 w_jr_wk      [DEPTH+1];

    // Next-state arrays
    logic                 w_valid_nx   [DEPTH];
    logic [PAYLOAD_W-1:0] w_payload_nx [DEPTH];
    logic [PID_W-1:0]     w_rs_pid_nx  [DEPTH];
    logic                 w_rs_rdy_nx  [DEPTH];
    logic [PID_W-1:0]     w_rt_pid_nx  [DEPTH];
    logic                 w_rt_rdy_nx  [DEPTH];
    logic [ROB_TAG_W-1:0] w_rob_tag_nx [DEPTH];
    logic                 w_jr_nx      [DEPTH];
    logic [CNT_W-1:0]     w_count_nx;

    logic [DEPTH-1:0]     w_ready;
    logic [DEPTH-1:0]     w_kill;
    logic [SEL_W-1:0]     w_sel;
    logic [SEL_W-1:0]     w_sel_jr;
    logic [SEL_W-1:0]     w_sel_any;
    logic                 w_found_jr;
    logic                 w_found_any;
    logic                 w_issue;
    logic                 w_write;
    logic [CNT_W-1:0]     w_wr_idx;
    logic [CNT_W-1:0]     w_surv_cnt;
    logic [ROB_TAG_W-1:0] w_flush_age;
    logic                 w_new_rs_rdy;
    logic                 w_new_rt_rdy;

    assign iq_full = (r_count == CNT_W'(DEPTH));

    // Select: lowest-index ready JR first, else lowest-index ready entry, else index 0
    always_comb begin
        w_ready     = '0;
        w_sel_jr    = '0;
        w_sel_any   = '0;
        w_found_jr  = 1'b0;
        w_found_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_valid[i] & r_rs_rdy[i] & r_rt_rdy[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i] && r_jr[i] && !w_found_jr) begin
                w_sel_jr   = SEL_W'(i);
                w_found_jr = 1'b1;
            end
            if (w_ready[i] && !w_found_any) begin
                w_sel_any   = SEL_W'(i);
                w_found_any = 1'b1;
            end
        end
        if (w_found_jr) begin
            w_sel = w_sel_jr;
        end else if (w_found_any) begin
            w_sel = w_sel_any;
        end else begin
            w_sel = '0;
        end
    end

    assign iq_rdy       = |w_ready;
    assign iq_r_payload = r_payload[w_sel];
    assign iq_r_rs_pid  = r_rs_pid[w_sel];
    assign iq_r_rt_pid  = r_rt_pid[w_sel];
    assign iq_r_rob_tag = r_rob_tag[w_sel];
    assign iq_r_jr      = r_jr[w_sel];

    assign w_issue  = iu_r_en & iq_rdy;
    assign w_write  = du_w_en & ~iq_full;
    // Slot freed by a same-cycle issue is reused by the write
    assign w_wr_idx = w_issue ? (r_count - CNT_W'(1)) : r_count;

    // Age relative to the ROB head; an entry at or younger than the flushing tag is killed
    always_comb begin
        w_flush_age = ROB_TAG_W'(cdb_rob_tag - rob_r_ptr);
        w_kill      = '0;
        w_surv_cnt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i]  = (ROB_TAG_W'(r_rob_tag[i] - rob_r_ptr) >= w_flush_age);
            w_surv_cnt = w_surv_cnt + CNT_W'(r_valid[i] & ~w_kill[i]);
        end
    end

    // CDB wakeup applied to every valid entry
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_wk[i]   = r_valid[i];
            w_payload_wk[i] = r_payload[i];
            w_rs_pid_wk[i]  = r_rs_pid[i];
            w_rt_pid_wk[i]  = r_rt_pid[i];
            w_rob_tag_wk[i] = r_rob_tag[i];
            w_jr_wk[i]      = r_jr[i];
            w_rs_rdy_wk[i]  = r_rs_rdy[i] | (cdb_reg_wr & r_valid[i] & (r_rs_pid[i] == cdb_rd_pid));
            w_rt_rdy_wk[i]  = r_rt_rdy[i] | (cdb_reg_wr & r_valid[i] & (r_rt_pid[i] == cdb_rd_pid));
        end
        w_valid_wk[DEPTH]   = 1'b0;
        w_payload_wk[DEPTH] = '0;
        w_rs_pid_wk[DEPTH]  = '0;
        w_rs_rdy_wk[DEPTH]  = 1'b0;
        w_rt_pid_wk[DEPTH]  = '0;
        w_rt_rdy_wk[DEPTH]  = 1'b0;
        w_rob_tag_wk[DEPTH] = '0;
        w_jr_wk[DEPTH]      = 1'b0;
    end

    // Ready bits of the dispatching entry
    always_comb begin
`ifdef IQ_INT_WAKEUP_BYPASS_EN
        w_new_rs_rdy = du_w_rs_rdy | (cdb_reg_wr & (du_w_rs_pid == cdb_rd_pid));
        w_new_rt_rdy = du_w_rt_rdy | (cdb_reg_wr & (du_w_rt_pid == cdb_rd_pid));
`else
        w_new_rs_rdy = du_w_rs_rdy;
        w_new_rt_rdy = du_w_rt_rdy;
`endif
    end

    // Next state: flush truncates to the surviving prefix; otherwise collapse, then append
    always_comb begin
        w_valid_nx   = r_valid;
        w_payload_nx = r_payload;
        w_rs_pid_nx  = r_rs_pid;
        w_rs_rdy_nx  = r_rs_rdy;
        w_rt_pid_nx  = r_rt_pid;
        w_rt_rdy_nx  = r_rt_rdy;
        w_rob_tag_nx = r_rob_tag;
        w_jr_nx      = r_jr;
        w_count_nx   = r_count;
        if (cdb_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill[i]) begin
                    w_valid_nx[i]   = 1'b0;
                    w_payload_nx[i] = '0;
                    w_rs_pid_nx[i]  = '0;
                    w_rs_rdy_nx[i]  = 1'b0;
                    w_rt_pid_nx[i]  = '0;
                    w_rt_rdy_nx[i]  = 1'b0;
                    w_rob_tag_nx[i] = '0;
                    w_jr_nx[i]      = 1'b0;
                end
            end
            w_count_nx = w_surv_cnt;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue && (i >= int'(w_sel))) begin
                    w_valid_nx[i]   = w_valid_wk[i+1];
                    w_payload_nx[i] = w_payload_wk[i+1];
                    w_rs_pid_nx[i]  = w_rs_pid_wk[i+1];
                    w_rs_rdy_nx[i]  = w_rs_rdy_wk[i+1];
                    w_rt_pid_nx[i]  = w_rt_pid_wk[i+1];
                    w_rt_rdy_nx[i]  = w_rt_rdy_wk[i+1];
                    w_rob_tag_nx[i] = w_rob_tag_wk[i+1];
                    w_jr_nx[i]      = w_jr_wk[i+1];
                end else begin
                    w_valid_nx[i]   = w_valid_wk[i];
                    w_payload_nx[i] = w_payload_wk[i];
                    w_rs_pid_nx[i]  = w_rs_pid_wk[i];
                    w_rs_rdy_nx[i]  = w_rs_rdy_wk[i];
                    w_rt_pid_nx[i]  = w_rt_pid_wk[i];
                    w_rt_rdy_nx[i]  = w_rt_rdy_wk[i];
                    w_rob_tag_nx[i] = w_rob_tag_wk[i];
                    w_jr_nx[i]      = w_jr_wk[i];
                end
                if (w_write && (CNT_W'(i) == w_wr_idx)) begin
                    w_valid_nx[i]   = 1'b1;
                    w_payload_nx[i] = du_w_payload;
                    w_rs_pid_nx[i]  = du_w_rs_pid;
                    w_rs_rdy_nx[i]  = w_new_rs_rdy;
                    w_rt_pid_nx[i]  = du_w_rt_pid;
                    w_rt_rdy_nx[i]  = w_new_rt_rdy;
                    w_rob_tag_nx[i] = du_w_rob_tag;
                    w_jr_nx[i]      = du_w_jr;
                end
            end
            w_count_nx = r_count + CNT_W'(w_write) - CNT_W'(w_issue);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]   <= 1'b0;
                r_payload[i] <= '0;
                r_rs_pid[i]  <= '0;
                r_rs_rdy[i]  <= 1'b0;
                r_rt_pid[i]  <= '0;
                r_rt_rdy[i]  <= 1'b0;
                r_rob_tag[i] <= '0;
                r_jr[i]      <= 1'b0;
            end
            r_count <= '0;
        end else begin
            r_valid   <= w_valid_nx;
            r_payload <= w_payload_nx;
            r_rs_pid  <= w_rs_pid_nx;
            r_rs_rdy  <= w_rs_rdy_nx;
            r_rt_pid  <= w_rt_pid_nx;
            r_rt_rdy  <= w_rt_rdy_nx;
            r_rob_tag <= w_rob_tag_nx;
            r_jr      <= w_jr_nx;
            r_count   <= w_count_nx;
        end
    end

endmodule
